bft_leaf_interface: RTL and testbench

BFT_LEAF_INTERFACE -- requirements
Module: bft_leaf_interface

---
 rtl/bft_leaf_interface_pkg.sv | 25 ++
 rtl/bft_leaf_interface_fifo.sv | 50 +++++
 rtl/bft_leaf_interface.sv | 95 +++++++++
 tb/tb_bft_leaf_interface.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bft_leaf_interface_pkg.sv
// Packet layout helpers and classification type shared by the leaf interface and the tree switches.
// A packet is [valid | dest | payload], MSB first.
package bft_leaf_interface_pkg;

    typedef enum logic [1:0] {
        PKT_VOID,
        PKT_DELIVER,
        PKT_BOUNCE
    } pkt_class_t;

    localparam int BOUNCE_CNT_W = 16;

    function automatic int pkt_valid_bit(input int p_sz);
        return p_sz - 1;
    endfunction

    function automatic int pkt_dest_hi(input int p_sz);
        return p_sz - 2;
    endfunction

    function automatic int pkt_dest_lo(input int payload_sz);
        return payload_sz;
    endfunction

endpackage

// File: rtl/bft_leaf_interface_fifo.sv
// First-word-fall-through FIFO with synchronous reset.
// It accepts a push while full only if a pop happens in the same cycle.
module leaf_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_reg];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/bft_leaf_interface.sv
// Leaf endpoint of a butterfly-fat-tree: delivers or deflects every incoming packet
// and injects client packets into free bus slots.
module bft_leaf_interface
    import bft_leaf_interface_pkg::*;
#(
    parameter int num_leaves = 256,
    parameter int payload_sz = 43,
    parameter logic [$clog2(num_leaves)-1:0] addr = '0,
    parameter int p_sz = 1 + $clog2(num_leaves) + payload_sz,
    parameter int tx_depth = 8,
    parameter int rx_depth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [p_sz-1:0]       bus_i,
    output logic [p_sz-1:0]       bus_o,
    input  logic [p_sz-2:0]       tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [payload_sz-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [BOUNCE_CNT_W-1:0] bounce_cnt
);
    localparam int VB = pkt_valid_bit(p_sz);
    localparam int DH = pkt_dest_hi(p_sz);
    localparam int DL = pkt_dest_lo(payload_sz);

    logic [p_sz-2:0]         tx_head;
    logic                    tx_empty, tx_full, tx_push, tx_pop;
    logic [payload_sz-1:0]   rx_head;
    logic                    rx_empty, rx_full, rx_push, rx_pop;
    pkt_class_t              pkt_class;
    logic [p_sz-1:0]         bus_next;
    logic [BOUNCE_CNT_W-1:0] bounce_cnt_reg;

    assign tx_ready   = !tx_full;
    assign tx_push    = tx_valid && !tx_full;
    assign rx_valid   = !rx_empty;
    assign rx_data    = rx_head;
    assign rx_pop     = rx_valid && rx_ready;
    assign bounce_cnt = bounce_cnt_reg;

    // The network cannot stall, so a packet we cannot store must go straight back out.
    always_comb begin
        pkt_class = PKT_VOID;
        if (bus_i[VB]) begin
            if (bus_i[DH:DL] == addr && (!rx_full || rx_pop))
                pkt_class = PKT_DELIVER;
            else
                pkt_class = PKT_BOUNCE;
        end
        rx_push  = (pkt_class == PKT_DELIVER);
        tx_pop   = (pkt_class != PKT_BOUNCE) && !tx_empty;
        bus_next = '0;
        if (pkt_class == PKT_BOUNCE)
            bus_next = bus_i;
        else if (tx_pop)
            bus_next = {1'b1, tx_head};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_o          <= '0;
            bounce_cnt_reg <= '0;
        end else begin
            bus_o <= bus_next;
            if (pkt_class == PKT_BOUNCE && bounce_cnt_reg != '1)
                bounce_cnt_reg <= bounce_cnt_reg + 1'b1;
        end
    end

    leaf_fifo #(.width(p_sz - 1), .depth(tx_depth)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    leaf_fifo #(.width(payload_sz), .depth(rx_depth)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (bus_i[payload_sz-1:0]),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

endmodule

// File: tb/tb_bft_leaf_interface.sv
// Directed scenarios plus randomized traffic checked against a queue-based model of the leaf.
module tb_bft_leaf_interface;
    localparam int NL = 256;
    localparam int PS = 43;
    localparam int PKT = 52;
    localparam logic [7:0] ADDR = 8'h05;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [PKT-1:0]   bus_i;
    logic [PKT-1:0]   bus_o;
    logic [PKT-2:0]   tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [PS-1:0]    rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [15:0]      bounce_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PKT-2:0] tx_q[$];
    logic [PS-1:0]  rx_q[$];
    logic [PKT-1:0] exp_bus;
    logic [15:0]    exp_cnt;

    always #5 clk = ~clk;

    bft_leaf_interface #(
        .num_leaves (NL),
        .payload_sz (PS),
        .addr       (ADDR),
        .p_sz       (PKT),
        .tx_depth   (DEPTH),
        .rx_depth   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_i      (bus_i),
        .bus_o      (bus_o),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .bounce_cnt (bounce_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PKT-1:0] pkt(input logic [7:0] dest, input logic [PS-1:0] pl);
        return {1'b1, dest, pl};
    endfunction

    // Apply one cycle of inputs, advance the model by the leaf's rules, then compare.
    task automatic step(input logic r, input logic [PKT-1:0] bi, input logic tv,
                        input logic [PKT-2:0] td, input logic rr);
        logic pop_rx, deliver, bounce, push_tx;
        reset = r; bus_i = bi; tx_valid = tv; tx_data = td; rx_ready = rr;
        if (r) begin
            tx_q.delete(); rx_q.delete();
            exp_bus = '0; exp_cnt = '0;
        end else begin
            pop_rx  = (rx_q.size() != 0) && rr;
            deliver = bi[PKT-1] && (bi[PKT-2 -: 8] == ADDR) && (rx_q.size() < DEPTH || pop_rx);
            bounce  = bi[PKT-1] && !deliver;
            push_tx = tv && (tx_q.size() < DEPTH);
            if (pop_rx)  void'(rx_q.pop_front());
            if (deliver) rx_q.push_back(bi[PS-1:0]);
            if (bounce) begin
                exp_bus = bi;
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end else if (tx_q.size() != 0) begin
                exp_bus = {1'b1, tx_q.pop_front()};
            end else begin
                exp_bus = '0;
            end
            if (push_tx) tx_q.push_back(td);
        end
        @(posedge clk);
        @(negedge clk);
        check_val("bus_o", bus_o, exp_bus);
        check_val("bounce_cnt", bounce_cnt, exp_cnt);
        check_val("tx_ready", tx_ready, tx_q.size() < DEPTH);
        check_val("rx_valid", rx_valid, rx_q.size() != 0);
        if (rx_q.size() != 0) check_val("rx_data", rx_data, rx_q[0]);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, rr);
    endtask

    task automatic do_reset();
        step(1'b1, pkt(ADDR, 43'h7), 1'b1, 51'h1, 1'b0);
        check_val("reset_bus_o", bus_o, 64'd0);
        check_val("reset_tx_ready", tx_ready, 64'd1);
        check_val("reset_rx_valid", rx_valid, 64'd0);
        check_val("reset_cnt", bounce_cnt, 64'd0);
    endtask

    initial begin
        logic [63:0]    r64;
        logic [PKT-1:0] bi;
        logic [7:0]     dest;
        int             rr_pct;

        reset = 1'b1; bus_i = '0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
        exp_bus = '0; exp_cnt = '0;
        @(negedge clk);
        do_reset();
        do_reset();

        // Single send, then void.
        step(1'b0, '0, 1'b1, {8'h20, 43'h1}, 1'b1);
        check_val("send_not_yet", bus_o, 64'd0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        check_val("send_valid", bus_o, {1'b1, 8'h20, 43'h1});
        step(1'b0, '0, 1'b0, '0, 1'b1);
        check_val("send_void", bus_o, 64'd0);

        // Delivery.
        step(1'b0, pkt(ADDR, 43'hABC), 1'b0, '0, 1'b0);
        check_val("deliver_valid", rx_valid, 64'd1);
        check_val("deliver_data", rx_data, 64'hABC);
        check_val("deliver_void", bus_o, 64'd0);
        idle(2, 1'b1);

        // Deflection beats injection.
        do_reset();
        step(1'b0, '0, 1'b1, {8'h11, 43'h111}, 1'b1);
        step(1'b0, pkt(8'h07, 43'h5A5), 1'b1, {8'h12, 43'h222}, 1'b1);
        step(1'b0, pkt(8'h07, 43'h5A5), 1'b0, '0, 1'b1);
        step(1'b0, pkt(8'h07, 43'h5A5), 1'b0, '0, 1'b1);
        idle(3, 1'b1);
        check_val("deflect_cnt", bounce_cnt, 64'd3);

        // RX full: ninth packet bounces unchanged.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b0, pkt(ADDR, PS'(100 + i)), 1'b0, '0, 1'b0);
        check_val("rxfull_bounce", bus_o, pkt(ADDR, PS'(108)));
        check_val("rxfull_cnt", bounce_cnt, 64'd1);
        idle(10, 1'b1);

        // TX full while the bus is saturated by bounces.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b0, pkt(8'h33, PS'(i)), 1'b1, {8'h40, PS'(200 + i)}, 1'b1);
        check_val("txfull_ready", tx_ready, 64'd0);
        idle(10, 1'b1);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) step(1'b0, pkt(ADDR, PS'(i)), 1'b1, {8'h41, PS'(i)}, 1'b0);
        step(1'b0, pkt(8'h09, PS'(7)), 1'b1, {8'h42, PS'(7)}, 1'b0);
        do_reset();
        idle(2, 1'b1);

        // Randomized traffic with a slowly varying consumer.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) rr_pct = $urandom_range(10, 100);
            r64 = {$urandom, $urandom};
            bi = r64[PKT-1:0];
            dest = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ADDR;
            bi[PKT-2 -: 8] = dest;
            bi[PKT-1] = ($urandom_range(0, 99) < 45);
            r64 = {$urandom, $urandom};
            step(($urandom_range(0, 399) == 0), bi, $urandom_range(0, 1) == 1,
                 r64[PKT-2:0], ($urandom_range(1, 100) <= rr_pct));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
